// File: rtl/muldiv_if.sv
// muldiv_if: core <-> multiply/divide unit bus.
//   master (core side): drives start/op/in1/in2 and MTHI/MTLO writes,
//                       observes busy/done/div_by_zero and HI/LO.
//   slave  (unit side): the reverse.
//   start        launch op on in1/in2 (taken only while the unit is idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in1, in2     rs / rt operands
//   hi_we, lo_we MTHI / MTLO strobes, data on wdata
//   busy         operation in progress (stall)
//   done         one-cycle completion pulse, HI/LO valid with it
//   div_by_zero  sticky divide-by-zero flag
//   hi, lo       architectural HI/LO registers
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave (start/op/in1/in2, MTHI/MTLO, busy/done/div_by_zero, hi/lo)
// Flow: IDLE -> CALC (32 iterations, one per cycle) -> FIX (sign fix, HI/LO write) -> IDLE.
// Multiply is radix-2 shift-add, divide is restoring; both run on magnitudes in a
// shared 2*WIDTH accumulator.
// Build option: define MULDIV_DIV_EN to include the divider. Without it, DIV/DIVU
// complete in one cycle leaving HI/LO untouched and div_by_zero at 0.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [W2-1:0]    acc_reg;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0] opnd_reg;    // multiplicand or divisor magnitude
  logic             is_div_reg;
  logic             neg_p_reg;   // negate 64-bit product
  logic             neg_q_reg;   // negate quotient
  logic             neg_r_reg;   // negate remainder
  logic             wr_res_reg;  // FIX writes HI/LO
  logic             dz_pend_reg; // FIX raises div_by_zero
  logic             busy_reg;
  logic             done_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // Operand decode: op[0]=0 selects the signed variants.
  logic             op_div;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign op_div = bus.op[1];
  assign s1     = ~bus.op[0] & bus.in1[WIDTH-1];
  assign s2     = ~bus.op[0] & bus.in2[WIDTH-1];
  assign mag1   = s1 ? -bus.in1 : bus.in1;
  assign mag2   = s2 ? -bus.in2 : bus.in2;

  // Shift-add step: conditionally add multiplicand to the upper half, then
  // shift the whole accumulator right with the carry moving in at the top.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  logic [W2-1:0]   step_next;

  assign mul_sum  = {1'b0, acc_reg[W2-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring step: shift {rem, dividend} left one, trial-subtract the divisor
  // from the (WIDTH+1)-bit partial remainder. The extra top bit of the
  // difference is the borrow, so its inverse is the next quotient bit.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;
  logic [W2-1:0]  div_next;

  assign div_shift = acc_reg[W2-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                      acc_reg[WIDTH-2:0], div_ge};
  assign step_next = is_div_reg ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  // Sign correction applied in FIX.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;

  always_comb begin
    prod_fix = neg_p_reg ? -acc_reg : acc_reg;
    hi_fix   = prod_fix[W2-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      hi_fix = neg_r_reg ? -acc_reg[W2-1:WIDTH] : acc_reg[W2-1:WIDTH];
      lo_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_p_reg   <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      wr_res_reg  <= 1'b0;
      dz_pend_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // start takes priority over a same-cycle MTHI/MTLO
            busy_reg    <= 1'b1;
            dz_reg      <= 1'b0;
            cnt_reg     <= '0;
            is_div_reg  <= op_div;
            neg_p_reg   <= s1 ^ s2;
            neg_q_reg   <= s1 ^ s2;
            neg_r_reg   <= s1;
            wr_res_reg  <= 1'b1;
            dz_pend_reg <= 1'b0;
            if (op_div) begin
`ifdef MULDIV_DIV_EN
              opnd_reg <= mag2;
              if (bus.in2 == '0) begin
                // skip iteration: preload the architectural div-by-zero result
                acc_reg     <= {bus.in1, {WIDTH{1'b1}}};
                neg_q_reg   <= 1'b0;
                neg_r_reg   <= 1'b0;
                dz_pend_reg <= 1'b1;
                state_reg   <= FIX;
              end else begin
                acc_reg   <= {{WIDTH{1'b0}}, mag1};
                state_reg <= CALC;
              end
`else
              wr_res_reg <= 1'b0;
              state_reg  <= FIX;
`endif
            end else begin
              opnd_reg  <= mag1;
              acc_reg   <= {{WIDTH{1'b0}}, mag2};
              state_reg <= CALC;
            end
          end else begin
            if (bus.hi_we) hi_reg <= bus.wdata;
            if (bus.lo_we) lo_reg <= bus.wdata;
          end
        end
        CALC: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_reg <= FIX;
        end
        FIX: begin
          if (wr_res_reg) begin
            hi_reg <= hi_fix;
            lo_reg <= lo_fix;
          end
          dz_reg    <= dz_pend_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural result from plain arithmetic.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    int da;
    int db;
    exp_dz = 1'b0;
    case (op)
      2'd0: begin
        sa = $signed(a);
        sb = $signed(b);
        p = sa * sb;
        {exp_hi, exp_lo} = p;
      end
      2'd1: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        p = ua * ub;
        {exp_hi, exp_lo} = p;
      end
`ifdef MULDIV_DIV_EN
      2'd2: begin
        da = a;
        db = b;
        if (b == 32'd0) begin
          exp_lo = 32'hFFFFFFFF; exp_hi = a; exp_dz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          exp_lo = 32'h80000000; exp_hi = 32'd0;
        end else begin
          exp_lo = da / db;
          exp_hi = da % db;
        end
      end
      default: begin
        if (b == 32'd0) begin
          exp_lo = 32'hFFFFFFFF; exp_hi = a; exp_dz = 1'b1;
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
`else
      default: begin
        da = 0;
        db = 0;
      end
`endif
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    if (op[1]) return (b == 32'd0) ? 1 : 33;
`else
    if (op[1]) return 1;
`endif
    return 33;
  endfunction

  // Launch one op; returns edges from acceptance to done, busy-cycle count,
  // and div_by_zero sampled right after acceptance.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt, output logic dz0);
    bus.op = op; bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    model_op(op, a, b);
    tick();
    bus.start = 1'b0;
    dz0 = bus.div_by_zero;
    lat = 0;
    bcnt = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (bus.busy) bcnt++;
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d",
             op, a, b, bus.hi, bus.lo, bus.div_by_zero, lat, bcnt);
  endtask

  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] b,
                          input int lat, input int bcnt, input logic dz0);
    checks += 5;
    if (lat !== exp_lat(op, b)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(op, b)); end
    if (bcnt !== exp_lat(op, b)) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, exp_lat(op, b)); end
    if (bus.hi !== exp_hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, bus.hi, exp_hi); end
    if (bus.lo !== exp_lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, bus.lo, exp_lo); end
    if (bus.div_by_zero !== exp_dz) begin errors++; $display("FAIL %s dz: got %b expected %b", name, bus.div_by_zero, exp_dz); end
    checks++;
    if (dz0 !== 1'b0) begin errors++; $display("FAIL %s dz_clear_on_start: got %b expected 0", name, dz0); end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks += 5;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset dz: got %b expected 0", bus.div_by_zero); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  top [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
    logic [31:0] ta  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5, 32'd3};
    logic [31:0] tb  [7] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd9};
    int lat;
    int bcnt;
    logic dz0;
    for (int i = 0; i < 7; i++) begin
      do_op(top[i], ta[i], tb[i], lat, bcnt, dz0);
      check_op("directed", top[i], tb[i], lat, bcnt, dz0);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    int bcnt;
    logic dz0;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = (($urandom_range(0, 7)) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(op, a, b, lat, bcnt, dz0);
      check_op("random", op, b, lat, bcnt, dz0);
    end
  endtask

  task automatic test_mt();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus.wdata = v;
      bus.hi_we = (i != 1);
      bus.lo_we = (i != 0);
      if (i != 1) exp_hi = v;
      if (i != 0) exp_lo = v;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      checks += 2;
      if (bus.hi !== exp_hi) begin errors++; $display("FAIL mt hi: got %h expected %h", bus.hi, exp_hi); end
      if (bus.lo !== exp_lo) begin errors++; $display("FAIL mt lo: got %h expected %h", bus.lo, exp_lo); end
      $display("mt hi_we=%b lo_we=%b wdata=%h -> hi=%h lo=%h", i != 1, i != 0, v, bus.hi, bus.lo);
    end
  endtask

  task automatic test_ignore_while_busy();
    int lat;
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom; b = $urandom;
    bus.op = 2'd0; bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    model_op(2'd0, a, b);
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      bus.start = (lat == 10);
      bus.op = 2'd3;
      bus.in1 = $urandom;
      bus.in2 = 32'd0;
      bus.hi_we = (lat == 12);
      bus.wdata = 32'h1234;
      tick();
      lat++;
      bus.start = 1'b0; bus.hi_we = 1'b0;
    end
    $display("ignore: MULT a=%h b=%h -> hi=%h lo=%h lat=%0d", a, b, bus.hi, bus.lo, lat);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL ignore latency: got %0d expected 33", lat); end
    if (bus.hi !== exp_hi) begin errors++; $display("FAIL ignore hi: got %h expected %h", bus.hi, exp_hi); end
    if (bus.lo !== exp_lo) begin errors++; $display("FAIL ignore lo: got %h expected %h", bus.lo, exp_lo); end
    // MTHI in the done cycle (unit is idle again)
    bus.hi_we = 1'b1; bus.wdata = 32'h1234; exp_hi = 32'h1234;
    tick();
    bus.hi_we = 1'b0;
    checks += 3;
    if (bus.hi !== exp_hi) begin errors++; $display("FAIL ignore mthi hi: got %h expected %h", bus.hi, exp_hi); end
    if (bus.lo !== exp_lo) begin errors++; $display("FAIL ignore mthi lo: got %h expected %h", bus.lo, exp_lo); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_start_beats_write();
    int lat;
    int bcnt;
    logic dz0;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    do_op(2'd1, 32'h00012345, 32'h00000003, lat, bcnt, dz0);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check_op("start_wins", 2'd1, 32'h3, lat, bcnt, dz0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int bcnt;
    logic dz0;
    do_op(2'd0, 32'hFFFF0000, 32'h00010001, lat, bcnt, dz0);
    check_op("b2b_first", 2'd0, 32'h00010001, lat, bcnt, dz0);
    // next start issued in the done cycle; busy must not react combinationally
    bus.op = 2'd1; bus.in1 = 32'h7; bus.in2 = 32'h6; bus.start = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b busy_comb: got %b expected 0", bus.busy); end
    do_op(2'd1, 32'h7, 32'h6, lat, bcnt, dz0);
    check_op("b2b_second", 2'd1, 32'h6, lat, bcnt, dz0);
  endtask

  task automatic test_reset_mid_op();
    int ndone;
    logic [1:0] op;
`ifdef MULDIV_DIV_EN
    op = 2'd2;
`else
    op = 2'd0;
`endif
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = op; bus.in1 = 32'hFFFFFF00; bus.in2 = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b expected 0", bus.done); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL rst_mid hi: got %h expected 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL rst_mid lo: got %h expected 0", bus.lo); end
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    $display("rst_mid: done pulses after reset = %0d hi=%h lo=%h", ndone, bus.hi, bus.lo);
    checks += 3;
    if (ndone !== 0) begin errors++; $display("FAIL rst_mid spurious_done: got %0d expected 0", ndone); end
    if (bus.hi !== exp_hi) begin errors++; $display("FAIL rst_mid hi_after: got %h expected %h", bus.hi, exp_hi); end
    if (bus.lo !== exp_lo) begin errors++; $display("FAIL rst_mid lo_after: got %h expected %h", bus.lo, exp_lo); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.in1 = '0; bus.in2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_directed();
    test_mt();
    test_random();
    test_ignore_while_busy();
    test_start_beats_write();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the MIPS execute stage. It sits beside the ALU and takes the same two operands from the register file. It runs MULT/MULTU/DIV/DIVU over multiple cycles and holds the architectural HI/LO registers. The pipeline stalls on `busy`; HI/LO are read by MFHI/MFLO and written by MTHI/MTLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation `op` on `in1`/`in2`; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `in1`  in  32  rs operand (multiplicand / dividend)
- `in2`  in  32  rt operand (multiplier / divisor)
- `hi_we`  in  1  MTHI: HI <= `wdata`
- `lo_we`  in  1  MTLO: LO <= `wdata`
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress; core must stall
- `done`  out  1  one-cycle pulse; HI/LO valid in the same cycle
- `div_by_zero`  out  1  sticky flag; set with `done` of a DIV/DIVU with `in2`==0; cleared by the next accepted `start`
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- Reset (async, `rst_n`=0):
  - state = IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `hi` = `lo` = 0.
  - Iteration counter = 0.
  - Reset mid-operation aborts with no result write.
- IDLE, `start`=1:
  - Latch `op`, `in1`, `in2`.
  - For signed ops, latch the operand magnitudes and the result signs:
    - product sign = s1^s2
    - quotient sign = s1^s2
    - remainder sign = s1
  - Go to CALC; counter = 0.
- IDLE, `start`=1, DIV/DIVU with `in2`==0:
  - No iteration; go directly to FIX.
  - Result: `lo` = 0xFFFFFFFF, `hi` = `in1` (raw), `div_by_zero` = 1.
- CALC:
  - One iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring; 32-bit remainder plus 1 guard bit.
- FIX:
  - Apply two's-complement sign correction (signed ops only).
  - Write `hi` = product[63:32] / remainder and `lo` = product[31:0] / quotient.
  - Go to IDLE.
- Arithmetic: all results wrap modulo 2^32 per half. DIV 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
- `start` while not IDLE is ignored.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored while busy.
  - If `start` and a write occur in the same IDLE cycle, `start` wins and the write is dropped.
  - `hi_we` and `lo_we` together write both halves.

## Timing
- `start` accepted at edge E0. `busy` = 1 from E0 until the FIX edge E33.
- `hi`/`lo` update at E33. `done` = 1 for the cycle following E33.
- Latency from `start` to `done` is 33 cycles.
- Divide-by-zero: `busy` for 1 cycle; `done` after 1 cycle (IDLE -> FIX -> IDLE).
- A new `start` is accepted in the `done` cycle. Back-to-back throughput is 1 op per 34 cycles.
- `hi`/`lo` are registered outputs; MTHI/MTLO writes are visible the cycle after the edge.
- `busy` is registered, with no combinational path from `start`. The core drives its stall from `start | busy`.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath is compiled out.
  - DIV/DIVU accepted by `start` complete via IDLE -> FIX with `done` after 1 cycle.
  - `hi`/`lo` are unchanged and `div_by_zero` stays 0.
  - MULT/MULTU are unaffected.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `done` 33 cycles after `start`; `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `busy` high for exactly 33 cycles.
- MULT 0xFFFFFFFA (-6) × 7 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFD6 (-42).
- DIV -7 / 2 -> `lo` = 0xFFFFFFFD (-3), `hi` = 0xFFFFFFFF (-1). DIVU 100 / 7 -> `lo` = 14, `hi` = 2.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0. DIVU 5 / 0 -> `done` after 1 cycle; `lo` = 0xFFFFFFFF, `hi` = 5, `div_by_zero` = 1; next `start` clears it.
- `start` pulsed again at cycle 10 of a MULT, plus `hi_we` with `wdata` = 0x1234 at cycle 12 -> both ignored; the result of the first op lands intact; `hi_we` in the next IDLE cycle sets `hi` = 0x1234.
- `rst_n` low at cycle 20 of a DIV -> `busy`/`done`/`hi`/`lo` = 0 immediately; no `done` follows. Rebuild without `MULDIV_DIV_EN`: DIVU 100 / 7 -> `done` after 1 cycle, `hi`/`lo` unchanged.
